// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM states and the row-sample classifier.
package keypad_pkg;

   localparam int MAX_ROWS  = 8;
   localparam int ROW_IDX_W = 3;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_REPORT,
      ST_WAIT_RELEASE
   } state_e;

   typedef enum logic [1:0] {
      ROW_IDLE,
      ROW_HIT,
      ROW_GHOST
   } row_class_e;

   typedef struct packed {
      row_class_e             cls;
      logic [ROW_IDX_W-1:0]   idx;
   } row_sample_t;

   // Rows are active-low: one zero is a hit, none is idle, more is a ghost.
   function automatic row_sample_t classify_rows(input logic [MAX_ROWS-1:0] rows_n);
      row_sample_t res;
      int          zeros;
      res.idx = '0;
      zeros   = 0;
      for (int i = 0; i < MAX_ROWS; i++) begin
         if (!rows_n[i]) begin
            zeros++;
            res.idx = ROW_IDX_W'(i);
         end
      end
      res.cls = (zeros == 0) ? ROW_IDLE : ((zeros == 1) ? ROW_HIT : ROW_GHOST);
      return res;
   endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows; resets to all ones (idle).
module row_sync #(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] i_row,
   output logic [WIDTH-1:0] o_row
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // NOTE: non-blocking assignments keep the two stages as distinct flops.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_row;
         r_sync <= r_meta;
      end
   end

   assign o_row = r_sync;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// ROWS x COLS keypad scanner: column dwell, press/release debounce, ghost rejection,
// and a Valid/Ack handshake with sticky overrun.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter  int ROWS     = 4,
   parameter  int COLS     = 4,
   parameter  int SCAN_DIV = 16,
   parameter  int DEBOUNCE = 8,
   localparam int CODE_W   = $clog2(ROWS*COLS)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ROWS-1:0]   Row,
   output logic [COLS-1:0]   Col,
   output logic [CODE_W-1:0] Code,
   output logic              Valid,
   input  logic              Ack,
   output logic              Held,
   output logic              Overrun
);

   localparam int COL_W   = $clog2(COLS);
   localparam int DWELL_W = $clog2(SCAN_DIV);
   localparam int DEB_W   = $clog2(DEBOUNCE+1);

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV-1);
   localparam logic [DEB_W-1:0]   DEB_TARGET = DEB_W'(DEBOUNCE);
   localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS-1);

   logic [ROWS-1:0] w_srow;

   row_sync #(.WIDTH(ROWS)) u_row_sync (
      .Clk   (Clk),
      .Reset (Reset),
      .i_row (Row),
      .o_row (w_srow)
   );

   state_e                 r_state;
   logic [COL_W-1:0]       r_col_idx;
   logic [DWELL_W-1:0]     r_dwell;
   logic [DEB_W-1:0]       r_deb;
   logic [ROW_IDX_W-1:0]   r_row_idx;
   logic [COLS-1:0]        r_col;
   logic [CODE_W-1:0]      r_code;
   logic                   r_valid;
   logic                   r_held;
   logic                   r_overrun;

   state_e                 w_state_nxt;
   logic [COL_W-1:0]       w_col_idx_nxt;
   logic [DWELL_W-1:0]     w_dwell_nxt;
   logic [DEB_W-1:0]       w_deb_nxt;
   logic [ROW_IDX_W-1:0]   w_row_idx_nxt;
   logic [COLS-1:0]        w_col_nxt;
   logic [CODE_W-1:0]      w_code_nxt;
   logic                   w_valid_nxt;
   logic                   w_held_nxt;
   logic                   w_overrun_nxt;

   logic [MAX_ROWS-1:0]    w_row_pad;
   row_sample_t            w_cls;
   logic                   w_sample;
   logic                   w_hit;
   logic                   w_idle;
   logic [COL_W-1:0]       w_col_adv;
   logic [DEB_W-1:0]       w_deb_inc;
   logic [CODE_W-1:0]      w_new_code;

   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      w_row_pad           = '1;
      w_row_pad[ROWS-1:0] = w_srow;
      w_cls               = classify_rows(w_row_pad);
      w_hit               = (w_cls.cls == ROW_HIT);
      w_idle              = (w_cls.cls == ROW_IDLE);
      w_sample            = (r_dwell == DWELL_LAST);
      w_dwell_nxt         = w_sample ? '0 : r_dwell + 1'b1;
      w_col_adv           = (r_col_idx == COL_LAST) ? '0 : r_col_idx + 1'b1;
      w_deb_inc           = (r_deb == DEB_TARGET) ? r_deb : r_deb + 1'b1;
      w_new_code          = CODE_W'(int'(r_row_idx) * COLS + int'(r_col_idx));

      w_state_nxt         = r_state;
      w_col_idx_nxt       = r_col_idx;
      w_deb_nxt           = r_deb;
      w_row_idx_nxt       = r_row_idx;
      w_code_nxt          = r_code;
      w_valid_nxt         = r_valid;
      w_held_nxt          = r_held;
      w_overrun_nxt       = r_overrun;

      if (r_valid && Ack) begin
         w_valid_nxt   = 1'b0;
         w_overrun_nxt = 1'b0;
      end

      unique case (r_state)
         ST_SCAN: begin
            if (w_sample) begin
               if (w_hit) begin
                  w_row_idx_nxt = w_cls.idx;
                  w_deb_nxt     = DEB_W'(1);
                  w_state_nxt   = (DEBOUNCE == 1) ? ST_REPORT : ST_DEBOUNCE;
               end else begin
                  w_col_idx_nxt = w_col_adv;
               end
            end
         end
         ST_DEBOUNCE: begin
            if (w_sample) begin
               if (w_hit && (w_cls.idx == r_row_idx)) begin
                  w_deb_nxt = w_deb_inc;
                  if (w_deb_inc == DEB_TARGET) w_state_nxt = ST_REPORT;
               end else begin
                  w_deb_nxt     = '0;
                  w_col_idx_nxt = w_col_adv;
                  w_state_nxt   = ST_SCAN;
               end
            end
         end
         ST_REPORT: begin
            // A pending unacknowledged code is kept; the new press is flagged as lost.
            if (r_valid && !Ack) w_overrun_nxt = 1'b1;
            else                 w_code_nxt    = w_new_code;
            w_valid_nxt = 1'b1;
            w_held_nxt  = 1'b1;
            w_deb_nxt   = '0;
            w_state_nxt = ST_WAIT_RELEASE;
         end
         ST_WAIT_RELEASE: begin
            if (w_sample) begin
               if (!w_idle) begin
                  w_deb_nxt = '0;
               end else if (w_deb_inc == DEB_TARGET) begin
                  w_deb_nxt     = '0;
                  w_held_nxt    = 1'b0;
                  w_col_idx_nxt = w_col_adv;
                  w_state_nxt   = ST_SCAN;
               end else begin
                  w_deb_nxt = w_deb_inc;
               end
            end
         end
      endcase

      w_col_nxt = ~(COLS'(1) << w_col_idx_nxt);
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state   <= ST_SCAN;
         r_col_idx <= '0;
         r_dwell   <= '0;
         r_deb     <= '0;
         r_row_idx <= '0;
         r_col     <= ~(COLS'(1));
         r_code    <= '0;
         r_valid   <= 1'b0;
         r_held    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_col_idx <= w_col_idx_nxt;
         r_dwell   <= w_dwell_nxt;
         r_deb     <= w_deb_nxt;
         r_row_idx <= w_row_idx_nxt;
         r_col     <= w_col_nxt;
         r_code    <= w_code_nxt;
         r_valid   <= w_valid_nxt;
         r_held    <= w_held_nxt;
         r_overrun <= w_overrun_nxt;
      end
   end

   assign Col     = r_col;
   assign Code    = r_code;
   assign Valid   = r_valid;
   assign Held    = r_held;
   assign Overrun = r_overrun;

endmodule
